// File: rtl/gpio_bram_arbiter_if.sv
// Requester-side bus of gpio_bram_arbiter: per-requester request slices packed side by side,
// plus the one-hot grant/response and the lock-break pulse.
interface gpio_bram_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 1
);
  localparam int unsigned MaskWidth = DataWidth / 8;

  logic [NumReq-1:0]           req_i;
  logic [NumReq-1:0]           lock_i;
  logic [NumReq-1:0]           we_i;
  logic [NumReq*MaskWidth-1:0] wmask_i;
  logic [NumReq*AddrWidth-1:0] addr_i;
  logic [NumReq*DataWidth-1:0] wdata_i;
  logic [NumReq-1:0]           gnt_o;
  logic [NumReq-1:0]           rvalid_o;
  logic [DataWidth-1:0]        rdata_o;
  logic                        lock_break_o;

  modport master (
    output req_i, lock_i, we_i, wmask_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, lock_break_o
  );

  modport slave (
    input  req_i, lock_i, we_i, wmask_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, lock_break_o
  );
endinterface

// File: rtl/gpio_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM-style register port between NumReq requesters,
// with per-requester lock for atomic sequences and an optional idle timeout on the lock.
module gpio_bram_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 1,
  parameter int unsigned LockTimeout = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  gpio_bram_arbiter_if.slave       bus,
  output logic                     bram_en_o,
  output logic                     bram_we_o,
  output logic [DataWidth/8-1:0]   bram_wmask_o,
  output logic [AddrWidth-1:0]     bram_addr_o,
  output logic [DataWidth-1:0]     bram_wdata_o,
  input  logic [DataWidth-1:0]     bram_rdata_i
);
  localparam int unsigned MaskWidth = DataWidth / 8;
  localparam int unsigned PtrWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntWidth  = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax  = '1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(LockTimeout - 1);

  typedef enum logic [1:0] {
    ST_RR     = 2'd0,
    ST_LOCKED = 2'd1,
    ST_BREAK  = 2'd2
  } state_e;

  state_e                r_state;
  logic [PtrWidth-1:0]   r_ptr;
  logic [PtrWidth-1:0]   r_owner;
  logic [CntWidth-1:0]   r_cnt;
  logic [NumReq-1:0]     r_rvalid;
  logic                  r_lock_break;

  state_e                w_state_d;
  logic [PtrWidth-1:0]   w_ptr_d;
  logic [PtrWidth-1:0]   w_owner_d;
  logic [CntWidth-1:0]   w_cnt_d;
  logic                  w_break_d;
  logic                  w_gnt_vld;
  logic [PtrWidth-1:0]   w_gnt_idx;
  logic [PtrWidth-1:0]   w_scan;
  logic [NumReq-1:0]     w_gnt;

  function automatic logic [PtrWidth-1:0] f_next(input logic [PtrWidth-1:0] idx);
    return (32'(idx) == NumReq - 1) ? '0 : idx + PtrWidth'(1);
  endfunction

  // Grant selection and next-state; nothing is granted while reset is held.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_owner_d = r_owner;
    w_cnt_d   = r_cnt;
    w_break_d = 1'b0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    w_gnt     = '0;
    if (rst_ni) begin
      unique case (r_state)
        ST_RR: begin
          w_cnt_d = '0;
          for (int unsigned i = 0; i < NumReq; i++) begin
            w_scan = PtrWidth'((32'(r_ptr) + i) % NumReq);
            if (!w_gnt_vld && bus.req_i[w_scan]) begin
              w_gnt_vld = 1'b1;
              w_gnt_idx = w_scan;
            end
          end
          if (w_gnt_vld) begin
            if (bus.lock_i[w_gnt_idx]) begin
              w_state_d = ST_LOCKED;
              w_owner_d = w_gnt_idx;
            end else begin
              w_ptr_d = f_next(w_gnt_idx);
            end
          end
        end
        ST_LOCKED: begin
          if (bus.req_i[r_owner]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = r_owner;
            w_cnt_d   = '0;
            if (!bus.lock_i[r_owner]) begin
              w_state_d = ST_RR;
              w_ptr_d   = f_next(r_owner);
            end
          end else if ((LockTimeout != 0) && (r_cnt == CntLast)) begin
            w_state_d = ST_BREAK;
            w_ptr_d   = f_next(r_owner);
            w_break_d = 1'b1;
            w_cnt_d   = '0;
          end else if (r_cnt != CntMax) begin
            w_cnt_d = r_cnt + CntWidth'(1);
          end
        end
        // One dead cycle after a forced release before round-robin resumes.
        ST_BREAK: w_state_d = ST_RR;
        default:  w_state_d = ST_RR;
      endcase
      if (w_gnt_vld) w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  // Downstream mux from the granted slice; zero when idle.
  always_comb begin
    bram_en_o    = w_gnt_vld;
    bram_we_o    = 1'b0;
    bram_wmask_o = '0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    if (w_gnt_vld) begin
      bram_we_o    = bus.we_i[w_gnt_idx];
      bram_wmask_o = bus.wmask_i[32'(w_gnt_idx)*MaskWidth +: MaskWidth];
      bram_addr_o  = bus.addr_i[32'(w_gnt_idx)*AddrWidth +: AddrWidth];
      bram_wdata_o = bus.wdata_i[32'(w_gnt_idx)*DataWidth +: DataWidth];
    end
  end

  assign bus.gnt_o        = w_gnt;
  assign bus.rvalid_o     = r_rvalid;
  assign bus.rdata_o      = bram_rdata_i;
  assign bus.lock_break_o = r_lock_break;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_RR;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_cnt        <= '0;
      r_rvalid     <= '0;
      r_lock_break <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_ptr        <= w_ptr_d;
      r_owner      <= w_owner_d;
      r_cnt        <= w_cnt_d;
      r_rvalid     <= w_gnt;
      r_lock_break <= w_break_d;
    end
  end
endmodule

// File: tb/tb_gpio_bram_arbiter.sv
// Self-checking bench for gpio_bram_arbiter: directed vector table, reset sequences,
// then random traffic against a behavioural arbitration/memory model.
module tb_gpio_bram_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 1;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned TO = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           bram_en_o;
  logic           bram_we_o;
  logic [MW-1:0]  bram_wmask_o;
  logic [AW-1:0]  bram_addr_o;
  logic [DW-1:0]  bram_wdata_o;
  logic [DW-1:0]  bram_rdata_i;

  gpio_bram_arbiter_if #(.NumReq(N), .DataWidth(DW), .AddrWidth(AW)) bus ();

  gpio_bram_arbiter #(
    .NumReq(N), .DataWidth(DW), .AddrWidth(AW), .LockTimeout(TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus          (bus),
    .bram_en_o    (bram_en_o),
    .bram_we_o    (bram_we_o),
    .bram_wmask_o (bram_wmask_o),
    .bram_addr_o  (bram_addr_o),
    .bram_wdata_o (bram_wdata_o),
    .bram_rdata_i (bram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Downstream register file; preloaded while reset is held.
  logic [DW-1:0] mem [2];
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      mem[0]       <= 32'hDEAD_BEEF;
      mem[1]       <= 32'h0000_FFFF;
      bram_rdata_i <= '0;
    end else if (bram_en_o) begin
      if (bram_we_o) begin
        for (int b = 0; b < MW; b++)
          if (bram_wmask_o[b]) mem[bram_addr_o][8*b +: 8] <= bram_wdata_o[8*b +: 8];
      end else begin
        bram_rdata_i <= mem[bram_addr_o];
      end
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  logic [N-1:0]  d_req, d_lock, d_we;
  logic [AW-1:0] d_addr  [N];
  logic [MW-1:0] d_wmask [N];
  logic [DW-1:0] d_wdata [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic apply();
    bus.req_i  = d_req;
    bus.lock_i = d_lock;
    bus.we_i   = d_we;
    for (int k = 0; k < N; k++) begin
      bus.addr_i[k*AW +: AW]  = d_addr[k];
      bus.wmask_i[k*MW +: MW] = d_wmask[k];
      bus.wdata_i[k*DW +: DW] = d_wdata[k];
    end
  endtask

  task automatic check_cycle(input logic [N-1:0] eg, input logic [N-1:0] erv, input logic ebrk,
                             input logic rdchk, input logic [DW-1:0] erd);
    int g;
    g = -1;
    for (int k = 0; k < N; k++) if (eg[k]) g = k;
    chk("gnt", 64'(bus.gnt_o), 64'(eg));
    chk("rvalid", 64'(bus.rvalid_o), 64'(erv));
    chk("lock_break", 64'(bus.lock_break_o), 64'(ebrk));
    chk("bram_en", 64'(bram_en_o), 64'(g >= 0));
    if (g >= 0) begin
      chk("bram_addr", 64'(bram_addr_o), 64'(d_addr[g]));
      chk("bram_we", 64'(bram_we_o), 64'(d_we[g]));
      chk("bram_wmask", 64'(bram_wmask_o), 64'(d_wmask[g]));
      chk("bram_wdata", 64'(bram_wdata_o), 64'(d_wdata[g]));
    end else begin
      chk("bram_idle", {bram_we_o, bram_wmask_o, bram_addr_o, bram_wdata_o}, 64'd0);
    end
    if (rdchk) chk("rdata", 64'(bus.rdata_o), 64'(erd));
  endtask

  typedef struct {
    logic [1:0]  req, lock, we, addr, gnt, rv;
    logic        brk;
    logic        rdchk;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(logic [1:0] req, logic [1:0] lock, logic [1:0] we, logic [1:0] addr,
                              logic [1:0] gnt, logic [1:0] rv, logic brk, logic rdchk,
                              logic [31:0] rd);
    vec_t v;
    v = '{req, lock, we, addr, gnt, rv, brk, rdchk, rd};
    return v;
  endfunction

  vec_t tbl [17];

  // Behavioural model state: owner -1 means no lock held.
  int            m_owner, m_ptr, m_idle;
  bit            m_brk, m_prev_brk, m_pend_rd;
  logic [N-1:0]  m_prev_gnt;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] smem [2];

  initial begin
    // fairness, read data, lock/unlock, timeout
    tbl[0]  = mk(2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 32'h0);
    tbl[1]  = mk(2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 0, 1, 32'hDEAD_BEEF);
    tbl[2]  = mk(2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 0, 1, 32'h0000_FFFF);
    tbl[3]  = mk(2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 0, 1, 32'hDEAD_BEEF);
    tbl[4]  = mk(2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 0, 1, 32'h0000_FFFF);
    tbl[5]  = mk(2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 0, 1, 32'hDEAD_BEEF);
    tbl[6]  = mk(2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 0, 1, 32'hDEAD_BEEF);
    tbl[7]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 0, 0, 32'h0);
    tbl[8]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1, 32'hA5A5_A5A5);
    tbl[9]  = mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 32'h0);
    tbl[10] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1, 32'hA5A5_A5A5);
    tbl[11] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0);
    tbl[12] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0);
    tbl[13] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0);
    tbl[14] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 32'h0);
    tbl[15] = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0, 32'h0);
    tbl[16] = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 0, 1, 32'hA5A5_A5A5);

    d_wdata[0] = 32'h0123_4567;
    d_wdata[1] = 32'hA5A5_A5A5;
    for (int k = 0; k < N; k++) begin
      d_wmask[k] = '1;
      d_addr[k]  = '0;
    end

    // Reset held with every requester asking.
    rst_ni = 1'b0;
    d_req = 2'b11; d_lock = '0; d_we = '0;
    apply();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_gnt", 64'(bus.gnt_o), 64'd0);
    chk("reset_en", 64'(bram_en_o), 64'd0);
    chk("reset_rvalid", 64'(bus.rvalid_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 17; i++) begin
      d_req = tbl[i].req; d_lock = tbl[i].lock; d_we = tbl[i].we;
      d_addr[0] = tbl[i].addr[0];
      d_addr[1] = tbl[i].addr[1];
      apply();
      @(negedge clk_i);
      check_cycle(tbl[i].gnt, tbl[i].rv, tbl[i].brk, tbl[i].rdchk, tbl[i].rd);
      @(posedge clk_i); #1;
    end

    // Reset right after a grant: the response is dropped and the pointer returns to 0.
    d_req = 2'b01; d_lock = '0; d_we = '0; d_addr[0] = '0; d_addr[1] = '0;
    apply();
    @(negedge clk_i);
    chk("midrst_gnt", 64'(bus.gnt_o), 64'b01);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst_rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("midrst_gnt_held", 64'(bus.gnt_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    d_req = 2'b11;
    apply();
    @(negedge clk_i);
    chk("midrst_ptr", 64'(bus.gnt_o), 64'b01);
    chk("midrst_rvalid_after", 64'(bus.rvalid_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    d_req = '0;
    apply();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    smem[0] = mem[0];
    smem[1] = mem[1];
    m_owner = -1; m_ptr = 0; m_idle = 0;
    m_brk = 0; m_prev_brk = 0; m_pend_rd = 0;
    m_prev_gnt = '0; m_rd = '0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [N-1:0] eg;
      int gi;
      bit nbrk;
      // Pending requesters keep their payload (occasionally withdrawing).
      for (int k = 0; k < N; k++) begin
        if (!(d_req[k] && !m_prev_gnt[k] && $urandom_range(0, 9) != 0)) begin
          d_req[k]   = ($urandom_range(0, 99) < 55);
          d_lock[k]  = ($urandom_range(0, 3) == 0);
          d_we[k]    = 1'($urandom_range(0, 1));
          d_addr[k]  = AW'($urandom);
          d_wmask[k] = MW'($urandom);
          d_wdata[k] = $urandom;
        end
      end
      apply();
      @(negedge clk_i);

      gi = -1;
      if (m_brk) gi = -1;
      else if (m_owner >= 0) begin
        if (d_req[m_owner]) gi = m_owner;
      end else begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (gi < 0 && d_req[k]) gi = k;
        end
      end
      eg = '0;
      if (gi >= 0) eg[gi] = 1'b1;

      check_cycle(eg, m_prev_gnt, m_prev_brk, m_pend_rd, m_rd);

      m_pend_rd = 0;
      if (gi >= 0) begin
        if (d_we[gi]) begin
          for (int b = 0; b < MW; b++)
            if (d_wmask[gi][b]) smem[d_addr[gi]][8*b +: 8] = d_wdata[gi][8*b +: 8];
        end else begin
          m_pend_rd = 1;
          m_rd = smem[d_addr[gi]];
        end
      end
      nbrk = 0;
      if (m_brk) m_brk = 0;
      else if (m_owner >= 0) begin
        if (gi >= 0) begin
          m_idle = 0;
          if (!d_lock[gi]) begin
            m_ptr = (gi + 1) % N;
            m_owner = -1;
          end
        end else if (TO != 0 && m_idle == TO - 1) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          m_brk = 1;
          nbrk = 1;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end else if (gi >= 0) begin
        if (d_lock[gi]) begin
          m_owner = gi;
          m_idle = 0;
        end else begin
          m_ptr = (gi + 1) % N;
        end
      end
      m_prev_brk = nbrk;
      m_prev_gnt = eg;
      @(posedge clk_i); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
